// File: rtl/prbs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prbs_pkg
// Brief    : Shared PRBS7/PRBS15 encodings, lane-state enum and LFSR helpers.
// Revision : 1.0
// ============================================================================
package prbs_pkg;

   localparam logic PRBS7  = 1'b0;
   localparam logic PRBS15 = 1'b1;
   localparam int   L7     = 7;
   localparam int   L15    = 15;

   // Widest word the helpers handle; DATA_W must stay below this.
   localparam int   MAX_W  = 64;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      SYNC   = 2'd1,
      LOCKED = 2'd2
   } lane_state_t;

   typedef struct packed {
      logic [14:0]      state;
      logic [MAX_W-1:0] word;
   } prbs_step_t;

   // Runs nbits LFSR steps; word bit nbits-1 holds the earliest output bit.
   function automatic prbs_step_t prbs_advance(input logic [14:0] state,
                                               input logic        mode,
                                               input int          nbits);
      prbs_step_t r;
      logic       nb;
      r.state = state;
      r.word  = '0;
      for (int i = 0; i < MAX_W; i++) begin
         if (i < nbits) begin
            if (mode == PRBS15) begin
               nb      = r.state[L15-1] ^ r.state[L15-2];
               r.state = {r.state[13:0], nb};
            end else begin
               nb      = r.state[L7-1] ^ r.state[L7-2];
               r.state = {8'd0, r.state[5:0], nb};
            end
            r.word = {r.word[MAX_W-2:0], nb};
         end
      end
      return r;
   endfunction

   function automatic logic [7:0] popcount(input logic [MAX_W-1:0] v);
      logic [7:0] n;
      n = '0;
      for (int i = 0; i < MAX_W; i++) begin
         n = n + {7'd0, v[i]};
      end
      return n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/prbs_lane_checker.sv
`default_nettype none
// ============================================================================
// Module   : prbs_lane_checker
// Brief    : One lane of self-synchronising PRBS lock FSM and error counter.
// Revision : 1.0
// ============================================================================
module prbs_lane_checker
   import prbs_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int CNT_W    = 32,
   parameter int SYNC_CNT = 8,
   parameter int LOSS_CNT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_mode,
   input  logic              i_flush,
   input  logic              i_valid,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_clr_cnt,
   output logic              o_lock,
   output logic              o_err,
   output logic [CNT_W-1:0]  o_err_cnt
);

   localparam int c_gw = $clog2(SYNC_CNT + 1);
   localparam int c_bw = $clog2(LOSS_CNT + 1);
   localparam int c_sw = CNT_W + 9;
   localparam logic [c_gw-1:0]  c_good_last = c_gw'(SYNC_CNT - 1);
   localparam logic [c_bw-1:0]  c_bad_last  = c_bw'(LOSS_CNT - 1);
   localparam logic [CNT_W-1:0] c_cnt_max   = '1;

   lane_state_t       r_state;
   logic [14:0]       r_chk;
   logic [c_gw-1:0]   r_good;
   logic [c_bw-1:0]   r_bad;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_lock;
   logic              r_err;

   prbs_step_t        w_adv;
   logic [DATA_W-1:0] w_diff;
   logic              w_match;
   logic [14:0]       w_seed;
   logic [7:0]        w_pop;
   logic              w_err_now;
   logic [CNT_W-1:0]  w_base;
   logic [c_sw-1:0]   w_sum;
   logic [CNT_W-1:0]  w_cnt_next;
   logic              w_unused_word;

   assign w_adv         = prbs_advance(r_chk, i_mode, DATA_W);
   assign w_unused_word = ^w_adv.word[MAX_W-1:DATA_W];
   assign w_diff        = i_data ^ w_adv.word[DATA_W-1:0];
   assign w_match       = (w_diff == '0);
   assign w_seed        = (i_mode == PRBS15) ? i_data[14:0] : {8'd0, i_data[6:0]};
   assign w_pop         = popcount(MAX_W'(w_diff));
   assign w_err_now     = i_valid && !i_flush && (r_state == LOCKED) && !w_match;

   // Clear and a same-cycle error combine: the count restarts from this word.
   assign w_base     = i_clr_cnt ? '0 : r_cnt;
   assign w_sum      = c_sw'(w_base) + c_sw'(w_pop);
   assign w_cnt_next = !w_err_now ? w_base :
                       (w_sum > c_sw'(c_cnt_max)) ? c_cnt_max : w_sum[CNT_W-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= HUNT;
         r_chk   <= '0;
         r_good  <= '0;
         r_bad   <= '0;
         r_cnt   <= '0;
         r_lock  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_cnt <= w_cnt_next;
         r_err <= w_err_now;
         if (i_flush) begin
            r_state <= HUNT;
            r_lock  <= 1'b0;
            r_good  <= '0;
            r_bad   <= '0;
         end else if (i_valid) begin
            case (r_state)
               HUNT: begin
                  if (w_seed != '0) begin
                     r_chk   <= w_seed;
                     r_good  <= '0;
                     r_state <= SYNC;
                  end
               end
               SYNC: begin
                  if (w_match) begin
                     r_chk <= w_adv.state;
                     if (r_good == c_good_last) begin
                        r_state <= LOCKED;
                        r_lock  <= 1'b1;
                        r_bad   <= '0;
                     end else begin
                        r_good <= r_good + c_gw'(1);
                     end
                  end else begin
                     r_state <= HUNT;
                  end
               end
               LOCKED: begin
                  // Track from the prediction so a bad word cannot corrupt the state.
                  r_chk <= w_adv.state;
                  if (!w_match) begin
                     if (r_bad == c_bad_last) begin
                        r_state <= HUNT;
                        r_lock  <= 1'b0;
                     end else begin
                        r_bad <= r_bad + c_bw'(1);
                     end
                  end else begin
                     r_bad <= '0;
                  end
               end
               default: begin
                  r_state <= HUNT;
                  r_lock  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign o_lock    = r_lock;
   assign o_err     = r_err;
   assign o_err_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/prbs_multilane_checker.sv
`default_nettype none
// ============================================================================
// Module   : prbs_multilane_checker
// Brief    : PRBS7/15 word generator plus LANES independent lock checkers.
// Revision : 1.0
// ============================================================================
module prbs_multilane_checker
   import prbs_pkg::*;
#(
   parameter int LANES    = 4,
   parameter int DATA_W   = 16,
   parameter int CNT_W    = 32,
   parameter int SYNC_CNT = 8,
   parameter int LOSS_CNT = 4
) (
   input  logic                    RX_CLK_G,
   input  logic                    RESET,
   input  logic                    PRBS_MODE,
   input  logic                    GEN_EN,
   output logic [DATA_W-1:0]       PRBSGEN_DATA,
   input  logic [LANES*DATA_W-1:0] RXD_DATA,
   input  logic [LANES-1:0]        RXD_VALID,
   input  logic                    CLR_CNT,
   output logic [LANES-1:0]        PRBS_LOCK,
   output logic [LANES-1:0]        PRBS_ERR,
   output logic [LANES*CNT_W-1:0]  PRBS_ERR_CNT
);

   logic              r_mode;
   logic [14:0]       r_gen_state;
   logic [DATA_W-1:0] r_gen_data;

   prbs_step_t        w_gen_step;
   logic              w_mode_chg;
   logic              w_unused_gen;

   assign w_gen_step   = prbs_advance(r_gen_state, r_mode, DATA_W);
   assign w_unused_gen = ^w_gen_step.word[MAX_W-1:DATA_W];
   assign w_mode_chg   = (PRBS_MODE != r_mode);

   // A mode change restarts the sequence from all-ones; the output word holds.
   always_ff @(posedge RX_CLK_G) begin
      if (RESET) begin
         r_mode      <= PRBS7;
         r_gen_state <= '1;
         r_gen_data  <= '0;
      end else begin
         r_mode <= PRBS_MODE;
         if (w_mode_chg) begin
            r_gen_state <= '1;
         end else if (GEN_EN) begin
            r_gen_state <= w_gen_step.state;
            r_gen_data  <= w_gen_step.word[DATA_W-1:0];
         end
      end
   end

   assign PRBSGEN_DATA = r_gen_data;

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lanes
      prbs_lane_checker #(
         .DATA_W   (DATA_W),
         .CNT_W    (CNT_W),
         .SYNC_CNT (SYNC_CNT),
         .LOSS_CNT (LOSS_CNT)
      ) u_lane (
         .clk       (RX_CLK_G),
         .rst       (RESET),
         .i_mode    (r_mode),
         .i_flush   (w_mode_chg),
         .i_valid   (RXD_VALID[gi]),
         .i_data    (RXD_DATA[gi*DATA_W +: DATA_W]),
         .i_clr_cnt (CLR_CNT),
         .o_lock    (PRBS_LOCK[gi]),
         .o_err     (PRBS_ERR[gi]),
         .o_err_cnt (PRBS_ERR_CNT[gi*CNT_W +: CNT_W])
      );
   end

endmodule
`default_nettype wire

// File: tb/tb_prbs_multilane_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_prbs_multilane_checker
// Brief    : Scoreboard bench: behavioural lane/generator model vs two DUTs.
// Revision : 1.0
// ============================================================================
module tb_prbs_multilane_checker;

   localparam int MH = 0, MS = 1, ML = 2;

   logic         clk = 1'b0;
   logic         rst = 1'b1, mode = 1'b0, gen_en = 1'b0, clr = 1'b0, z1 = 1'b0;
   logic [3:0]   valid = '0;
   logic [63:0]  rxd = '0;
   logic [15:0]  gen, s_gen;
   logic [3:0]   lock, err, s_lock, s_err;
   logic [127:0] cnt;
   logic [15:0]  s_cnt;

   always #5 clk = ~clk;

   prbs_multilane_checker dut (
      .RX_CLK_G(clk), .RESET(rst), .PRBS_MODE(mode), .GEN_EN(gen_en),
      .PRBSGEN_DATA(gen), .RXD_DATA(rxd), .RXD_VALID(valid), .CLR_CNT(clr),
      .PRBS_LOCK(lock), .PRBS_ERR(err), .PRBS_ERR_CNT(cnt)
   );

   prbs_multilane_checker #(.CNT_W(4)) dut_sat (
      .RX_CLK_G(clk), .RESET(rst), .PRBS_MODE(mode), .GEN_EN(gen_en),
      .PRBSGEN_DATA(s_gen), .RXD_DATA(rxd), .RXD_VALID(valid), .CLR_CNT(clr),
      .PRBS_LOCK(s_lock), .PRBS_ERR(s_err), .PRBS_ERR_CNT(s_cnt)
   );

   int n_total = 0, n_bad = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   // Reference model state
   logic        m_mode = 1'b0;
   logic [14:0] m_gs   = '1;
   logic [15:0] m_gd   = '0;
   int          m_st[4], m_good[4], m_bad[4], m_scnt[4];
   logic [14:0] m_chk[4];
   longint      m_cnt[4];
   logic [3:0]  m_lock = '0, m_err = '0;

   typedef struct {
      logic [15:0]  gen;
      logic [3:0]   lock;
      logic [3:0]   err;
      logic [127:0] cnt;
      logic [15:0]  scnt;
   } exp_t;
   exp_t sb[$];

   // Serial PRBS: x[n] = x[n-L] ^ x[n-L+1], history kept with newest bit at 0.
   function automatic void mdl_word(input logic [14:0] s_in, input logic m,
                                    output logic [14:0] s_out, output logic [15:0] w);
      int          len;
      logic        b;
      logic [14:0] s;
      len = m ? 15 : 7;
      s   = s_in;
      w   = '0;
      for (int k = 0; k < 16; k++) begin
         b = s[len-1] ^ s[len-2];
         s = ((s << 1) | 15'(b)) & 15'((1 << len) - 1);
         w = {w[14:0], b};
      end
      s_out = s;
   endfunction

   task automatic step(input logic [3:0] v, input logic [63:0] flip, input logic c);
      exp_t        e;
      logic [14:0] ns, sd;
      logic [15:0] pw, rw, d;
      int          pc;
      for (int i = 0; i < 4; i++) rxd[i*16 +: 16] = m_gd ^ flip[i*16 +: 16];
      if (z1) rxd[31:16] = '0;
      valid = v;
      clr   = c;
      if (rst) begin
         m_mode = 1'b0; m_gs = '1; m_gd = '0; m_lock = '0; m_err = '0;
         for (int i = 0; i < 4; i++) begin
            m_st[i] = MH; m_good[i] = 0; m_bad[i] = 0; m_cnt[i] = 0; m_scnt[i] = 0; m_chk[i] = '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            m_err[i] = 1'b0;
            rw = rxd[i*16 +: 16];
            d  = '0;
            if (mode != m_mode) begin
               m_st[i] = MH; m_lock[i] = 1'b0;
            end else if (v[i]) begin
               mdl_word(m_chk[i], m_mode, ns, pw);
               d = rw ^ pw;
               if (m_st[i] == MH) begin
                  sd = m_mode ? rw[14:0] : {8'd0, rw[6:0]};
                  if (sd != 0) begin m_chk[i] = sd; m_st[i] = MS; m_good[i] = 0; end
               end else if (m_st[i] == MS) begin
                  if (d == 0) begin
                     m_chk[i] = ns; m_good[i]++;
                     if (m_good[i] == 8) begin m_st[i] = ML; m_lock[i] = 1'b1; m_bad[i] = 0; end
                  end else m_st[i] = MH;
               end else begin
                  m_chk[i] = ns;
                  if (d != 0) begin
                     m_err[i] = 1'b1; m_bad[i]++;
                     if (m_bad[i] == 4) begin m_st[i] = MH; m_lock[i] = 1'b0; end
                  end else m_bad[i] = 0;
               end
            end
            if (c) begin m_cnt[i] = 0; m_scnt[i] = 0; end
            if (m_err[i]) begin
               pc = $countones(d);
               m_cnt[i]  = m_cnt[i] + pc;
               m_scnt[i] = m_scnt[i] + pc;
               if (m_cnt[i] > 64'hFFFF_FFFF) m_cnt[i] = 64'hFFFF_FFFF;
               if (m_scnt[i] > 15) m_scnt[i] = 15;
            end
         end
         if (mode != m_mode) m_gs = '1;
         else if (gen_en) mdl_word(m_gs, m_mode, m_gs, m_gd);
         m_mode = mode;
      end
      e.gen = m_gd; e.lock = m_lock; e.err = m_err;
      for (int i = 0; i < 4; i++) begin
         e.cnt[i*32 +: 32] = 32'(m_cnt[i]);
         e.scnt[i*4 +: 4]  = 4'(m_scnt[i]);
      end
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      check("gen", gen, e.gen);
      check("lock", lock, e.lock);
      check("err", err, e.err);
      check("cnt", cnt, e.cnt);
      check("sat_lock", s_lock, e.lock);
      check("sat_cnt", s_cnt, e.scnt);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      // Reset
      @(negedge clk);
      rst = 1'b1;
      step(4'h0, 64'h0, 1'b0);
      step(4'h0, 64'h0, 1'b0);
      check("rst_gen", gen, 16'h0);
      check("rst_lock", lock, 4'h0);
      check("rst_cnt", cnt, 128'h0);

      // Lock: loopback under PRBS7, lock on the 9th valid word
      rst = 1'b0; gen_en = 1'b1;
      step(4'h0, 64'h0, 1'b0);
      for (int k = 1; k <= 9; k++) begin
         step(4'hF, 64'h0, 1'b0);
         if (k == 8) check("lock_early", lock, 4'h0);
      end
      check("lock_9", lock, 4'hF);
      for (int k = 0; k < 4; k++) step(4'hF, 64'h0, 1'b0);
      check("lock_cnt0", cnt, 128'h0);
      check("lock_noerr", err, 4'h0);

      // Single 3-bit error on lane 2
      step(4'hF, 64'h0000_0007_0000_0000, 1'b0);
      check("err_l2", err, 4'b0100);
      check("cnt_l2", cnt[95:64], 32'd3);
      check("hold_l2", lock, 4'hF);
      step(4'hF, 64'h0, 1'b0);
      check("err_clear", err, 4'h0);
      for (int k = 0; k < 3; k++) step(4'hF, 64'h0000_0001_0000_0000, 1'b0);
      check("badclr_l2", lock[2], 1'b1);
      step(4'hF, 64'h0, 1'b0);

      // Loss of lock on lane 0, then relock
      for (int k = 1; k <= 4; k++) begin
         step(4'hF, 64'h1, 1'b0);
         if (k == 3) check("loss_hold", lock[0], 1'b1);
      end
      check("loss_drop", lock[0], 1'b0);
      check("loss_cnt", cnt[31:0], 32'd4);
      for (int k = 1; k <= 9; k++) begin
         step(4'hF, 64'h0, 1'b0);
         if (k == 8) check("relock_early", lock[0], 1'b0);
      end
      check("relock", lock, 4'hF);

      // Saturation on lane 3 then clear with a 2-bit error
      step(4'hF, 64'hFFFF_0000_0000_0000, 1'b0);
      step(4'hF, 64'hFFFF_0000_0000_0000, 1'b0);
      check("sat15", s_cnt[15:12], 4'd15);
      check("nosat32", cnt[127:96], 32'd32);
      step(4'hF, 64'h0003_0000_0000_0000, 1'b1);
      check("clr_err", cnt, {32'd2, 96'd0});
      check("clr_err_sat", s_cnt, 16'h2000);
      step(4'hF, 64'h0, 1'b0);
      step(4'hF, 64'h0, 1'b1);
      check("clr_only", cnt, 128'h0);

      // Mode toggle to PRBS15 and relock
      mode = 1'b1;
      step(4'hF, 64'h0, 1'b0);
      check("mode_drop", lock, 4'h0);
      step(4'h0, 64'h0, 1'b0);
      for (int k = 1; k <= 9; k++) begin
         step(4'hF, 64'h0, 1'b0);
         if (k == 8) check("p15_early", lock, 4'h0);
      end
      check("p15_lock", lock, 4'hF);

      // Reset mid-stream after an error
      step(4'hF, 64'h1, 1'b0);
      check("pre_rst_err", err, 4'h1);
      rst = 1'b1;
      step(4'hF, 64'h0, 1'b0);
      check("mid_rst_gen", gen, 16'h0);
      check("mid_rst_lock", lock, 4'h0);
      check("mid_rst_err", err, 4'h0);
      check("mid_rst_cnt", cnt, 128'h0);
      mode = 1'b0;
      step(4'h0, 64'h0, 1'b0);

      // Zero input on lane 1 from reset
      rst = 1'b0; z1 = 1'b1;
      step(4'h0, 64'h0, 1'b0);
      for (int k = 0; k < 12; k++) step(4'hF, 64'h0, 1'b0);
      check("zero_lock", lock, 4'b1101);
      check("zero_cnt", cnt[63:32], 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/prbs_multilane_checker.md
# prbs_multilane_checker

Parametrised multi-lane PRBS generator and self-synchronising checker for the RX IOD bit-alignment path. It generalises the single-lane PRBS7 generator and error flag in several ways: configurable lane count and word width, runtime PRBS7/PRBS15 selection, and a per-lane lock state machine with hysteresis and saturating bit-error counters. It sits in the RX_CLK_G fabric domain after the bit-alignment IODs, and drives the TX loopback data during link training.

## Interface
- LANES, 4: number of independent checker lanes.
- DATA_W, 16: bits per lane per word; must be ≥15.
- CNT_W, 32: width of each lane's error counter.
- SYNC_CNT, 8: consecutive clean words required to lock.
- LOSS_CNT, 4: consecutive errored words that drop lock.

- RX_CLK_G  in  1  fabric clock for all logic.
- RESET  in  1  reset. Synchronous to RX_CLK_G, active-high.
- PRBS_MODE  in  1  polynomial select. 0 = PRBS7 (x^7+x^6+1); 1 = PRBS15 (x^15+x^14+1).
- GEN_EN  in  1  advances the generator by one word.
- PRBSGEN_DATA  out  DATA_W  generator word, replicated to every lane's TX.
- RXD_DATA  in  LANES*DATA_W  received words; lane i is bits [i*DATA_W +: DATA_W].
- RXD_VALID  in  LANES  per-lane word qualifier.
- CLR_CNT  in  1  clears all error counters.
- PRBS_LOCK  out  LANES  lane is in LOCKED.
- PRBS_ERR  out  LANES  one-cycle pulse for an errored word while LOCKED.
- PRBS_ERR_CNT  out  LANES*CNT_W  saturating bit-error count per lane.

## Operation
- Bit order: word bit DATA_W-1 is the earliest serial bit.
- LFSR step, L = 7 or 15:
  - new = s[L-1] ^ s[L-2];
  - s = {s[L-2:0], new};
  - the output bit is new.
- Generator:
  - state resets to all-ones;
  - when GEN_EN=1, run DATA_W steps; PRBSGEN_DATA <= those output bits, and the state advances;
  - otherwise the output and state hold.
- Per-lane checker FSM, states HUNT, SYNC, LOCKED. Only cycles with RXD_VALID[i]=1 act; all other cycles hold all lane state.
  - HUNT:
    - seed = the newest L bits of the word (bits L-1:0);
    - if the seed is all zeros, stay in HUNT;
    - otherwise load the checker state with the seed and go to SYNC with good_cnt=0.
  - SYNC:
    - predicted word = DATA_W steps from the checker state;
    - on a match, good_cnt++ and the state advances; good_cnt reaching SYNC_CNT moves to LOCKED with bad_cnt=0;
    - on any mismatch, go to HUNT;
    - errors are never counted in HUNT or SYNC.
  - LOCKED:
    - the state always advances from the prediction, never from received data, so errors do not propagate;
    - on a mismatch: PRBS_ERR pulses, the counter adds popcount(rx ^ predicted), and bad_cnt++;
    - bad_cnt reaching LOSS_CNT moves to HUNT;
    - on a match, bad_cnt=0.
- Counter rules:
  - saturates at 2^CNT_W-1;
  - CLR_CNT alone sets it to 0;
  - CLR_CNT together with an error sets it to that word's popcount.
- Mode change: PRBS_MODE is registered. When it differs from the registered value:
  - all lanes go to HUNT;
  - the generator is reseeded to all-ones;
  - the RX word in that cycle is discarded;
  - counters are kept.

## Timing
- Reset values: PRBSGEN_DATA=0, PRBS_LOCK=0, PRBS_ERR=0, PRBS_ERR_CNT=0, all lanes in HUNT, generator state all-ones.
- Reset mid-operation: every output and state returns to these values on the next edge.
- Generator latency: PRBSGEN_DATA updates on the edge where GEN_EN=1 is sampled.
- Checker latency: PRBS_ERR, PRBS_LOCK and PRBS_ERR_CNT reflect the word sampled at edge n by edge n+1.
- All outputs are registered; there is no combinational path from input to output.
- Minimum lock time: seed word + SYNC_CNT clean words. PRBS_LOCK rises 1 cycle after the last clean word.
- Lanes are fully independent; simultaneous errors on all lanes are each counted.

## Structure
- Package prbs_pkg holds:
  - mode encodings PRBS7/PRBS15 and constants L7=7, L15=15;
  - the lane-state enum {HUNT, SYNC, LOCKED};
  - the function prbs_advance(state, mode, nbits), returning the next state and output word;
  - a popcount function.
- Sub-module prbs_lane_checker contains one lane's FSM, good_cnt/bad_cnt and error counter. It is instantiated LANES times in a generate loop.
- The generator lives at top level.

## Test plan
- Lock: defaults, PRBS7, PRBSGEN_DATA looped to all four lanes, GEN_EN=RXD_VALID=1 continuously.
  - Required: PRBS_LOCK=4'b1111 exactly 9 words after the first valid word; no PRBS_ERR; counts stay 0.
- Single error: while locked, flip 3 bits of one lane-2 word.
  - Required: PRBS_ERR=4'b0100 for one cycle, lane-2 count=3, lock held, next clean word clears bad_cnt.
- Loss of lock: 4 consecutive errored words on lane 0 (1 flipped bit each).
  - Required: count=4, PRBS_LOCK[0] falls one cycle after the 4th word, relock after 9 clean words.
- Zero input: lane 1 driven with 16'h0000 continuously.
  - Required: lane 1 stays in HUNT, PRBS_LOCK[1]=0, count 0.
- Saturation and clear: CNT_W=4, 16 bits flipped per word, repeated.
  - Required: count saturates at 15.
  - CLR_CNT together with a 2-bit error word → count=2.
- Mode and reset: toggle PRBS_MODE while locked, then assert RESET mid-stream.
  - Required: lock drops the cycle after the toggle, relock under PRBS15 after 9 words.
  - Required: RESET returns all outputs to 0 on the next edge.
